cv32e40p_conv_post_wb: RTL and testbench

Downstream stage of the Winograd F(2x2,3x3) convolution engine in the EX-stage MAC unit. It accepts one 4-lane output tile (y0..y3, IN_W-bit signed) through a valid/ready handshake. It requantizes each lane (rounding arithmetic shift, saturation to 32 bit), optionally applies ReLU and 2x2 max-pool, then writes 1 or 4 words to data memory over an OBI-style req/gnt/rvalid port. This replaces the per-word, core-driven write-back loop with an autonomous writer.

---
 rtl/cv32e40p_pkg.sv | 25 ++
 rtl/cv32e40p_conv_post_wb_if.sv | 30 +++
 rtl/cv32e40p_conv_quant.sv | 45 ++++
 rtl/cv32e40p_conv_post_wb.sv | 166 ++++++++++++++++
 tb/tb_cv32e40p_conv_post_wb.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the Winograd convolution post-processing writer.
package cv32e40p_pkg;

    localparam int unsigned CONV_IN_W    = 68;
    localparam int unsigned CONV_OUT_W   = 32;
    localparam int unsigned CONV_SHIFT_W = 6;

    typedef enum logic [2:0] {
        CP_IDLE,
        CP_QUANT,
        CP_POOL,
        CP_WRITE,
        CP_WAIT_RSP
    } conv_post_state_e;

    localparam logic signed [CONV_OUT_W-1:0] OUT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [CONV_OUT_W-1:0] OUT_MIN = 32'sh8000_0000;
    localparam logic [3:0]                   BE_ALL  = 4'hF;

    function automatic logic signed [CONV_OUT_W-1:0] smax(input logic signed [CONV_OUT_W-1:0] a,
                                                          input logic signed [CONV_OUT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cv32e40p_conv_post_wb_if.sv
// Tile input handshake plus OBI-style write port of the convolution post-processing writer.
interface cv32e40p_conv_post_wb_if #(
    parameter int unsigned IN_W  = 68,
    parameter int unsigned OUT_W = 32
) ();
    logic             tile_valid_i;
    logic             tile_ready_o;
    logic [IN_W-1:0]  y0_i;
    logic [IN_W-1:0]  y1_i;
    logic [IN_W-1:0]  y2_i;
    logic [IN_W-1:0]  y3_i;

    logic             data_req_o;
    logic             data_gnt_i;
    logic [31:0]      data_addr_o;
    logic             data_we_o;
    logic [3:0]       data_be_o;
    logic [OUT_W-1:0] data_wdata_o;
    logic             data_rvalid_i;

    modport slave (
        input  tile_valid_i, y0_i, y1_i, y2_i, y3_i, data_gnt_i, data_rvalid_i,
        output tile_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
    );

    modport master (
        output tile_valid_i, y0_i, y1_i, y2_i, y3_i, data_gnt_i, data_rvalid_i,
        input  tile_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
    );
endinterface

// File: rtl/cv32e40p_conv_quant.sv
// One-lane requantizer: round-half-up arithmetic shift, saturate to OUT_W, optional ReLU.
module cv32e40p_conv_quant
    import cv32e40p_pkg::*;
#(
    parameter int unsigned IN_W    = CONV_IN_W,
    parameter int unsigned OUT_W   = CONV_OUT_W,
    parameter int unsigned SHIFT_W = CONV_SHIFT_W
) (
    input  logic [IN_W-1:0]    y_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               relu_i,
    output logic [OUT_W-1:0]   q_o,
    output logic               sat_o
);
    localparam int unsigned EXT_W = IN_W + 1;

    logic signed [EXT_W-1:0] y_ext, rnd, sum, v, hi, lo;
    logic        [OUT_W-1:0] clamped;

    assign hi = EXT_W'(OUT_MAX);
    assign lo = EXT_W'(OUT_MIN);

    // One guard bit keeps the rounding add from overflowing for any input.
    always_comb begin
        y_ext = EXT_W'($signed(y_i));
        rnd   = '0;
        if (shift_i != '0) begin
            rnd = EXT_W'(1) << (shift_i - SHIFT_W'(1));
        end
        sum = y_ext + rnd;
        v   = sum >>> shift_i;

        sat_o   = 1'b0;
        clamped = v[OUT_W-1:0];
        if (v > hi) begin
            clamped = hi[OUT_W-1:0];
            sat_o   = 1'b1;
        end else if (v < lo) begin
            clamped = lo[OUT_W-1:0];
            sat_o   = 1'b1;
        end

        q_o = (relu_i && clamped[OUT_W-1]) ? '0 : clamped;
    end
endmodule

// File: rtl/cv32e40p_conv_post_wb.sv
// Autonomous write-back for one Winograd output tile: requantize, optional ReLU/max-pool,
// then write 1 or 4 words through an OBI-style port with one transaction outstanding.
module cv32e40p_conv_post_wb
    import cv32e40p_pkg::*;
#(
    parameter int unsigned IN_W    = CONV_IN_W,
    parameter int unsigned OUT_W   = CONV_OUT_W,
    parameter int unsigned SHIFT_W = CONV_SHIFT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cv32e40p_conv_post_wb_if.slave  bus,
    input  logic [SHIFT_W-1:0]      cfg_shift_i,
    input  logic                    cfg_relu_i,
    input  logic                    cfg_pool_i,
    input  logic [31:0]             cfg_base_i,
    input  logic [31:0]             cfg_stride_i,
    input  logic                    clear_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    sat_o
);
    conv_post_state_e        state_q, state_d;
    logic [1:0]              idx_q, idx_d, last_q, last_d;
    logic [IN_W-1:0]         y_q [4];
    logic [IN_W-1:0]         y_d [4];
    logic signed [OUT_W-1:0] q_q [4];
    logic signed [OUT_W-1:0] q_d [4];
    logic signed [OUT_W-1:0] qz  [4];
    logic [3:0]              qsat;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic                    relu_q, relu_d, pool_q, pool_d;
    logic [31:0]             base_q, base_d, stride_q, stride_d;
    logic                    sat_d, done_d, req_d, ready_d, busy_d;
    logic                    ready_q, req_q;
    logic [31:0]             addr_q, addr_d;
    logic [OUT_W-1:0]        wdata_q, wdata_d;

    for (genvar k = 0; k < 4; k++) begin : g_quant
        cv32e40p_conv_quant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_quant (
            .y_i     (y_q[k]),
            .shift_i (shift_q),
            .relu_i  (relu_q),
            .q_o     (qz[k]),
            .sat_o   (qsat[k])
        );
    end

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        y_d      = y_q;
        q_d      = q_q;
        shift_d  = shift_q;
        relu_d   = relu_q;
        pool_d   = pool_q;
        base_d   = base_q;
        stride_d = stride_q;
        sat_d    = clear_i ? 1'b0 : sat_o;
        done_d   = 1'b0;

        case (state_q)
            CP_IDLE: begin
                if (bus.tile_valid_i) begin
                    y_d[0]   = bus.y0_i;
                    y_d[1]   = bus.y1_i;
                    y_d[2]   = bus.y2_i;
                    y_d[3]   = bus.y3_i;
                    shift_d  = cfg_shift_i;
                    relu_d   = cfg_relu_i;
                    pool_d   = cfg_pool_i;
                    base_d   = cfg_base_i;
                    stride_d = cfg_stride_i;
                    idx_d    = 2'd0;
                    state_d  = CP_QUANT;
                end
            end
            CP_QUANT: begin
                q_d    = qz;
                last_d = 2'd3;
                if (|qsat) sat_d = 1'b1;
                state_d = pool_q ? CP_POOL : CP_WRITE;
            end
            CP_POOL: begin
                q_d[0]  = smax(smax(q_q[0], q_q[1]), smax(q_q[2], q_q[3]));
                last_d  = 2'd0;
                state_d = CP_WRITE;
            end
            CP_WRITE: begin
                if (bus.data_gnt_i) state_d = CP_WAIT_RSP;
            end
            CP_WAIT_RSP: begin
                if (bus.data_rvalid_i) begin
                    if (idx_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = CP_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = CP_WRITE;
                    end
                end
            end
            default: state_d = CP_IDLE;
        endcase

        // Outputs are decoded from the next state so they are glitch-free flops.
        req_d   = (state_d == CP_WRITE);
        ready_d = (state_d == CP_IDLE);
        busy_d  = !ready_d;
        addr_d  = '0;
        wdata_d = '0;
        if (req_d) begin
            addr_d  = base_q + (idx_d[1] ? stride_q : 32'd0) + (idx_d[0] ? 32'd4 : 32'd0);
            wdata_d = q_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CP_IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            y_q      <= '{default: '0};
            q_q      <= '{default: '0};
            shift_q  <= '0;
            relu_q   <= 1'b0;
            pool_q   <= 1'b0;
            base_q   <= '0;
            stride_q <= '0;
            sat_o    <= 1'b0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
            ready_q  <= 1'b1;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            y_q      <= y_d;
            q_q      <= q_d;
            shift_q  <= shift_d;
            relu_q   <= relu_d;
            pool_q   <= pool_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            sat_o    <= sat_d;
            done_o   <= done_d;
            busy_o   <= busy_d;
            ready_q  <= ready_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.tile_ready_o = ready_q;
    assign bus.data_req_o   = req_q;
    assign bus.data_we_o    = req_q;
    assign bus.data_be_o    = req_q ? BE_ALL : 4'h0;
    assign bus.data_addr_o  = addr_q;
    assign bus.data_wdata_o = wdata_q;
endmodule

// File: tb/tb_cv32e40p_conv_post_wb.sv
// Scoreboard bench for cv32e40p_conv_post_wb: expected writes are queued when a tile is sent
// and checked at each grant by a memory responder that can withhold grants.
module tb_cv32e40p_conv_post_wb;
    import cv32e40p_pkg::*;

    localparam int unsigned IN_W    = CONV_IN_W;
    localparam int unsigned OUT_W   = CONV_OUT_W;
    localparam int unsigned SHIFT_W = CONV_SHIFT_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [SHIFT_W-1:0] cfg_shift_i = '0;
    logic               cfg_relu_i = 1'b0;
    logic               cfg_pool_i = 1'b0;
    logic [31:0]        cfg_base_i = '0;
    logic [31:0]        cfg_stride_i = '0;
    logic               clear_i = 1'b0;
    logic               busy_o, done_o, sat_o;

    cv32e40p_conv_post_wb_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    cv32e40p_conv_post_wb #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .cfg_shift_i  (cfg_shift_i),
        .cfg_relu_i   (cfg_relu_i),
        .cfg_pool_i   (cfg_pool_i),
        .cfg_base_i   (cfg_base_i),
        .cfg_stride_i (cfg_stride_i),
        .clear_i      (clear_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sat_o        (sat_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  stall_at = -1;
    int  stall_left = 0;
    int  wcnt = 0;
    bit  pending = 1'b0;
    int  acc_cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference requantizer worked in 128-bit signed arithmetic.
    function automatic logic [31:0] mdl_q(input logic [67:0] y, input int sh, input bit relu);
        logic signed [127:0] t;
        t = {{60{y[67]}}, y};
        if (sh > 0) t = t + (128'sd1 <<< (sh - 1));
        t = t >>> sh;
        if (t > 128'sd2147483647) t = 128'sd2147483647;
        else if (t < -128'sd2147483648) t = -128'sd2147483648;
        if (relu && t < 0) t = 0;
        return t[31:0];
    endfunction

    task automatic push_model(input logic [67:0] y0, y1, y2, y3, input int sh, input bit relu, pool,
                              input logic [31:0] base, stride);
        logic [31:0] q [4];
        logic signed [31:0] m;
        q[0] = mdl_q(y0, sh, relu);
        q[1] = mdl_q(y1, sh, relu);
        q[2] = mdl_q(y2, sh, relu);
        q[3] = mdl_q(y3, sh, relu);
        if (pool) begin
            m = $signed(q[0]);
            for (int k = 1; k < 4; k++) if ($signed(q[k]) > m) m = $signed(q[k]);
            sb.push_back('{base, m});
        end else begin
            for (int k = 0; k < 4; k++)
                sb.push_back('{base + ((k >= 2) ? stride : 32'd0) + ((k % 2 == 1) ? 32'd4 : 32'd0), q[k]});
        end
    endtask

    // Call right after a negedge; returns on the negedge of the cycle after acceptance.
    task automatic send_tile(input logic [67:0] y0, y1, y2, y3, input int sh, input bit relu, pool,
                             input logic [31:0] base, stride, input bit hold);
        bit ok;
        bus.y0_i = y0; bus.y1_i = y1; bus.y2_i = y2; bus.y3_i = y3;
        cfg_shift_i = SHIFT_W'(sh);
        cfg_relu_i = relu;
        cfg_pool_i = pool;
        cfg_base_i = base;
        cfg_stride_i = stride;
        bus.tile_valid_i = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (bus.tile_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_val("accept_timeout", 64'(ok), 64'd1);
        acc_cyc = cyc;
        @(negedge clk);
        if (!hold) bus.tile_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check_val("done_timeout", 64'(seen), 64'd1);
        end else begin
            if (exp_lat > 0) check_val("done_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
            check_val("sb_drained", 64'(sb.size()), 64'd0);
            check_val("ready_at_done", 64'(bus.tile_ready_o), 64'd1);
            @(negedge clk);
            check_val("done_pulse", 64'(done_o), 64'd0);
        end
    endtask

    // Memory responder: grants (optionally withheld), returns rvalid one cycle after each grant.
    initial begin
        wr_t e;
        bus.data_gnt_i = 1'b0;
        bus.data_rvalid_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.data_gnt_i = 1'b0;
                bus.data_rvalid_i = 1'b0;
                pending = 1'b0;
            end else begin
                bus.data_rvalid_i = pending;
                pending = 1'b0;
                bus.data_gnt_i = 1'b0;
                if (bus.data_req_o) begin
                    if (sb.size() == 0) begin
                        check_val("sb_underrun", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb[0];
                        if (stall_left > 0 && wcnt == stall_at) begin
                            stall_left--;
                            check_val("held_addr", 64'(bus.data_addr_o), 64'(e.addr));
                            check_val("held_wdata", 64'(bus.data_wdata_o), 64'(e.data));
                        end else begin
                            bus.data_gnt_i = 1'b1;
                            void'(sb.pop_front());
                            check_val("wr_addr", 64'(bus.data_addr_o), 64'(e.addr));
                            check_val("wr_wdata", 64'(bus.data_wdata_o), 64'(e.data));
                            check_val("wr_we_be", 64'({bus.data_we_o, bus.data_be_o}), 64'h1F);
                            wcnt++;
                            pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [67:0] ya, yb, yc, yd;
        int sh;
        bit rl, pl;
        bit seen;
        bus.tile_valid_i = 1'b0;
        bus.y0_i = '0; bus.y1_i = '0; bus.y2_i = '0; bus.y3_i = '0;

        repeat (2) @(negedge clk);
        check_val("rst_ready", 64'(bus.tile_ready_o), 64'd1);
        check_val("rst_req", 64'({bus.data_req_o, bus.data_we_o, bus.data_be_o}), 64'd0);
        check_val("rst_addr", 64'(bus.data_addr_o), 64'd0);
        check_val("rst_wdata", 64'(bus.data_wdata_o), 64'd0);
        check_val("rst_status", 64'({busy_o, done_o, sat_o}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Four writes with rounding and one saturating lane.
        sb.push_back('{32'h1000, 32'd250});
        sb.push_back('{32'h1004, 32'(-250)});
        sb.push_back('{32'h1040, 32'h7FFF_FFFF});
        sb.push_back('{32'h1044, 32'hFFFF_FFFF});
        send_tile(68'd1000, -68'sd1000, 68'h100_0000_0000, -68'sd5, 2, 1'b0, 1'b0, 32'h1000, 32'h40, 1'b0);
        check_val("t1_req_c1", 64'(bus.data_req_o), 64'd0);
        check_val("t1_busy", 64'({busy_o, bus.tile_ready_o}), 64'b10);
        @(negedge clk);
        check_val("t1_req_c2", 64'(bus.data_req_o), 64'd1);
        wait_done(10);
        check_val("t1_sat", 64'(sat_o), 64'd1);

        // Max-pool, single word.
        sb.push_back('{32'h2000, 32'd5});
        send_tile(68'd7, -68'sd3, 68'd9, 68'd9, 1, 1'b0, 1'b1, 32'h2000, 32'h80, 1'b0);
        wait_done(5);

        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check_val("clear_sat", 64'(sat_o), 64'd0);

        // Max-pool with ReLU on an all-negative tile.
        sb.push_back('{32'h3000, 32'd0});
        send_tile(-68'sd8, -68'sd4, -68'sd12, -68'sd16, 0, 1'b1, 1'b1, 32'h3000, 32'h10, 1'b0);
        wait_done(5);
        check_val("t3_sat", 64'(sat_o), 64'd0);

        // Grant withheld for three cycles on the third word.
        ya = 68'd123456; yb = -68'sd777; yc = 68'hF_0000_1234_5678_9ABC; yd = 68'd3;
        push_model(ya, yb, yc, yd, 5, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_0100);
        stall_at = wcnt + 2;
        stall_left = 3;
        send_tile(ya, yb, yc, yd, 5, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_0100, 1'b0);
        wait_done(13);

        // Randomised tiles through the reference model, address wrap included.
        for (int t = 0; t < 4; t++) begin
            ya = {$urandom_range(15, 0), $urandom, $urandom};
            yb = 68'($signed($urandom));
            yc = {$urandom_range(15, 0), $urandom, $urandom};
            yd = 68'($signed($urandom_range(2000, 0)) - 1000);
            sh = (t == 0) ? 0 : int'($urandom_range(40, 1));
            rl = t[0];
            pl = t[1];
            push_model(ya, yb, yc, yd, sh, rl, pl, 32'hFFFF_FFF8, 32'h20);
            send_tile(ya, yb, yc, yd, sh, rl, pl, 32'hFFFF_FFF8, 32'h20, 1'b0);
            wait_done(pl ? 5 : 10);
        end

        // Second tile held while busy; accepted in the done cycle.
        push_model(68'd100, 68'd200, 68'd300, 68'd400, 1, 1'b0, 1'b0, 32'h5000, 32'h40);
        send_tile(68'd100, 68'd200, 68'd300, 68'd400, 1, 1'b0, 1'b0, 32'h5000, 32'h40, 1'b1);
        bus.y0_i = -68'sd11; bus.y1_i = 68'd22; bus.y2_i = -68'sd33; bus.y3_i = 68'd44;
        push_model(-68'sd11, 68'd22, -68'sd33, 68'd44, 1, 1'b0, 1'b0, 32'h5000, 32'h40);
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            check_val("t5_ready_busy", 64'(bus.tile_ready_o), 64'd0);
            @(negedge clk);
        end
        if (!seen) check_val("t5_done_timeout", 64'(seen), 64'd1);
        check_val("t5_done_latency", 64'(cyc - acc_cyc), 64'd10);
        check_val("t5_ready_done", 64'({bus.tile_ready_o, bus.tile_valid_i}), 64'b11);
        check_val("t5_sb_second", 64'(sb.size()), 64'd4);
        acc_cyc = cyc;
        @(negedge clk);
        bus.tile_valid_i = 1'b0;
        wait_done(10);

        // Reset while a request is being held.
        push_model(68'h7_FFFF_FFFF_FFFF, 68'd1, 68'd2, 68'd3, 0, 1'b0, 1'b0, 32'h6000, 32'h40);
        stall_at = wcnt;
        stall_left = 50;
        send_tile(68'h7_FFFF_FFFF_FFFF, 68'd1, 68'd2, 68'd3, 0, 1'b0, 1'b0, 32'h6000, 32'h40, 1'b0);
        @(negedge clk);
        check_val("t6_req_pre", 64'({bus.data_req_o, sat_o}), 64'b11);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_req_rst", 64'({bus.data_req_o, bus.data_we_o, bus.data_be_o}), 64'd0);
        check_val("t6_addr_rst", 64'(bus.data_addr_o), 64'd0);
        check_val("t6_wdata_rst", 64'(bus.data_wdata_o), 64'd0);
        check_val("t6_status_rst", 64'({busy_o, done_o, sat_o, bus.tile_ready_o}), 64'b0001);
        sb.delete();
        stall_left = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("t6_after_rel", 64'({bus.tile_ready_o, sat_o, busy_o, bus.data_req_o}), 64'b1000);

        // clear_i in the same cycle as a saturating QUANT: set wins.
        push_model(-68'sh8_0000_0000_0000, 68'd4, 68'd8, 68'd12, 2, 1'b0, 1'b0, 32'h7000, 32'h40);
        send_tile(-68'sh8_0000_0000_0000, 68'd4, 68'd8, 68'd12, 2, 1'b0, 1'b0, 32'h7000, 32'h40, 1'b0);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check_val("t6_sat_vs_clear", 64'(sat_o), 64'd1);
        wait_done(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
